// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-port arbiter in front of a single Avalon-MM SDRAM master interface.
//   An instruction-fetch read port and a data read/write port share the
//   SDRAM. At most one transaction is outstanding. Simultaneous requests are
//   resolved round-robin against the port granted last.
//
// Ports
//   CLOCK_50, reset          clock, synchronous active-high reset
//   i_req/i_addr             instruction read request (held until i_ack)
//   i_ack/i_rdata/i_err      one-cycle completion pulse, data, timeout flag
//   d_req/d_we/d_addr/d_wdata data-port request (held until d_ack)
//   d_ack/d_rdata/d_err      one-cycle completion pulse, data, timeout flag
//   avm_*                    Avalon-MM master towards the SDRAM controller
//   busy                     high whenever the FSM is not idle
module sdram_arbiter #(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              CLOCK_50,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,

    output logic              busy
);

    localparam int unsigned          CNT_W    = 10;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        RESP      = 2'd3
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t              state_q, state_d;
    port_t               owner_q, owner_d;
    port_t               last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timed_out;

    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_err_q, i_err_d;
    logic                d_err_q, d_err_d;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;
    logic                rd_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and transaction bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        timed_out    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the port that did not win last time is served.
                    if (i_req && d_req) begin
                        owner_d = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
                    end else if (i_req) begin
                        owner_d = PORT_I;
                    end else begin
                        owner_d = PORT_D;
                    end

                    if (owner_d == PORT_I) begin
                        we_d   = 1'b0;
                        addr_d = i_addr;
                    end else begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (!avm_waitrequest) begin
                    if (we_q) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT_DATA;
                        cnt_d   = '0;
                    end
                end
            end

            WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // This cycle brings the count to TIMEOUT_CYC.
                    state_d   = RESP;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output next-values (all outputs are registered)
    // ------------------------------------------------------------------
    always_comb begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (state_d == ISSUE) begin
            rd_d = !we_d;
            wr_d = we_d;
        end

        resp_rdata = avm_readdata;
        resp_err   = 1'b0;
        if (timed_out) begin
            resp_rdata = '0;
            resp_err   = 1'b1;
        end
        rd_done = (state_q == WAIT_DATA) && (state_d == RESP);

        i_ack_d   = (state_d == RESP) && (owner_d == PORT_I);
        d_ack_d   = (state_d == RESP) && (owner_d == PORT_D);
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_err_d   = i_err_q;
        d_err_d   = d_err_q;

        // Write completions leave the read-data register untouched.
        if (i_ack_d) begin
            i_err_d = resp_err;
            if (rd_done) begin
                i_rdata_d = resp_rdata;
            end
        end
        if (d_ack_d) begin
            d_err_d = resp_err;
            if (rd_done) begin
                d_rdata_d = resp_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            owner_q      <= PORT_I;
            last_grant_q <= PORT_D;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_writedata = wdata_q;
    assign avm_read      = rd_q;
    assign avm_write     = wr_q;
    assign i_ack         = i_ack_q;
    assign d_ack         = d_ack_q;
    assign i_rdata       = i_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign i_err         = i_err_q;
    assign d_err         = d_err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter (TIMEOUT_CYC = 8). Stimulus pushes the
//   expected SDRAM commands and port completions into queues; a negedge
//   monitor pops and compares whenever the DUT accepts a command or acks.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [24:0] i_addr = '0;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [24:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        d_err;
    logic [24:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy;

    sdram_arbiter #(
        .ADDR_W      (25),
        .DATA_W      (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .i_req             (i_req),
        .i_addr            (i_addr),
        .i_ack             (i_ack),
        .i_rdata           (i_rdata),
        .i_err             (i_err),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_ack             (d_ack),
        .d_rdata           (d_rdata),
        .d_err             (d_err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        bit          port;      // 0 = instruction, 1 = data
        logic [31:0] rdata;
        bit          err;
        bit          chk_data;
        int          cyc;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   acks_seen = 0;
    int   acks_exp  = 0;

    // SDRAM read responder: data returned the cycle after acceptance.
    bit          rsp_en   = 1'b1;
    logic [15:0] rsp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_cmd(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata;
        cmd_q.push_back(c);
    endtask

    task automatic exp_rsp(input bit port, input logic [31:0] rdata, input bit err,
                           input bit chk_data, input int at_cyc);
        rsp_t r;
        r.port = port; r.rdata = rdata; r.err = err; r.chk_data = chk_data; r.cyc = at_cyc;
        rsp_q.push_back(r);
        acks_exp++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit port, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (port ? d_ack : i_ack) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_ack: port %0d no ack within %0d cycles", port, budget);
        end
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (avm_read && !avm_waitrequest && rsp_en) begin
                @(posedge clk);
                #1;
                avm_readdatavalid = 1'b1;
                avm_readdata      = rsp_data;
                @(posedge clk);
                #1;
                avm_readdatavalid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (avm_read || avm_write) begin
            check("strobe_excl", 32'(avm_read & avm_write), 32'd0);
        end
        if ((avm_read || avm_write) && !avm_waitrequest) begin
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got addr 0x%0h we %0d, required none", avm_address, avm_write);
            end else begin
                c = cmd_q.pop_front();
                check("cmd_we", 32'(avm_write), 32'(c.we));
                check("cmd_addr", 32'(avm_address), c.addr);
                if (c.we) check("cmd_wdata", 32'(avm_writedata), c.wdata);
            end
        end
        if (i_ack || d_ack) begin
            acks_seen++;
            check("ack_excl", 32'(i_ack & d_ack), 32'd0);
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got i_ack %0d d_ack %0d, required none", i_ack, d_ack);
            end else begin
                r = rsp_q.pop_front();
                check("ack_port", 32'(d_ack), 32'(r.port));
                if (r.chk_data) check("ack_rdata", 32'(d_ack ? d_rdata : i_rdata), r.rdata);
                check("ack_err", 32'(d_ack ? d_err : i_err), 32'(r.err));
                check("ack_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_wdata", 32'(avm_writedata), 32'd0);
        check("rst_acks", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
        check("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        tick();
        reset = 1'b0;

        // Single instruction read
        tick();
        c = cyc;
        i_addr = 25'h00010; i_req = 1'b1; rsp_data = 16'hBEEF;
        exp_cmd(1'b0, 32'h10, 32'h0);
        exp_rsp(1'b0, 32'hBEEF, 1'b0, 1'b1, c + 3);
        @(negedge clk);
        @(negedge clk);
        check("read_strobe_c1", 32'(avm_read), 32'd1);
        wait_ack(1'b0, 20);
        tick();
        i_req = 1'b0;

        // Tie after reset: instr first; instr re-requests, second tie goes to data
        apply_reset();
        tick();
        c = cyc;
        i_addr = 25'h00030; i_req = 1'b1; rsp_data = 16'h1111;
        d_addr = 25'h00020; d_we = 1'b1; d_wdata = 16'h1234; d_req = 1'b1;
        exp_cmd(1'b0, 32'h30, 32'h0);
        exp_cmd(1'b1, 32'h20, 32'h1234);
        exp_cmd(1'b0, 32'h31, 32'h0);
        exp_rsp(1'b0, 32'h1111, 1'b0, 1'b1, c + 3);
        exp_rsp(1'b1, 32'h0, 1'b0, 1'b0, c + 6);
        exp_rsp(1'b0, 32'h2222, 1'b0, 1'b1, c + 10);
        wait_ack(1'b0, 20);
        tick();
        i_addr = 25'h00031; rsp_data = 16'h2222;
        wait_ack(1'b1, 20);
        tick();
        d_req = 1'b0;
        wait_ack(1'b0, 20);
        tick();
        i_req = 1'b0;

        // Data write stalled 4 cycles by waitrequest
        tick();
        c = cyc;
        d_addr = 25'h1ABCD; d_we = 1'b1; d_wdata = 16'h5A5A; d_req = 1'b1;
        avm_waitrequest = 1'b1;
        exp_cmd(1'b1, 32'h1ABCD, 32'h5A5A);
        exp_rsp(1'b1, 32'h0, 1'b0, 1'b0, c + 6);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("stall_write", 32'(avm_write), 32'd1);
            check("stall_addr", 32'(avm_address), 32'h1ABCD);
            check("stall_wdata", 32'(avm_writedata), 32'h5A5A);
            if (k == 4) begin
                @(posedge clk);
                #1;
                avm_waitrequest = 1'b0;
            end
        end
        wait_ack(1'b1, 20);
        check("stall_write_drop", 32'(avm_write), 32'd0);
        tick();
        d_req = 1'b0; d_we = 1'b0;

        // Read stalled 10 cycles (longer than timeout) still completes cleanly
        tick();
        c = cyc;
        i_addr = 25'h00040; i_req = 1'b1; rsp_data = 16'h7777;
        avm_waitrequest = 1'b1;
        exp_cmd(1'b0, 32'h40, 32'h0);
        exp_rsp(1'b0, 32'h7777, 1'b0, 1'b1, c + 13);
        repeat (11) tick();
        avm_waitrequest = 1'b0;
        wait_ack(1'b0, 20);
        tick();
        i_req = 1'b0;

        // Data read
        tick();
        c = cyc;
        d_addr = 25'h00055; d_we = 1'b0; d_req = 1'b1; rsp_data = 16'hCAFE;
        exp_cmd(1'b0, 32'h55, 32'h0);
        exp_rsp(1'b1, 32'hCAFE, 1'b0, 1'b1, c + 3);
        wait_ack(1'b1, 20);
        tick();
        d_req = 1'b0;

        // Timeout: 8 WAIT_DATA cycles without data, then a late return
        rsp_en = 1'b0;
        tick();
        c = cyc;
        d_addr = 25'h00066; d_req = 1'b1;
        exp_cmd(1'b0, 32'h66, 32'h0);
        exp_rsp(1'b1, 32'h0, 1'b1, 1'b1, c + 10);
        wait_ack(1'b1, 30);
        tick();
        d_req = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 16'hDEAD;
        tick();
        tick();
        avm_readdatavalid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("late_busy", 32'(busy), 32'd0);
        check("late_hold_rdata", 32'(d_rdata), 32'd0);
        check("late_hold_err", 32'(d_err), 32'd1);

        // Reset while waiting for read data
        tick();
        c = cyc;
        i_addr = 25'h00077; i_req = 1'b1;
        exp_cmd(1'b0, 32'h77, 32'h0);
        tick();
        tick();
        tick();
        reset = 1'b1; i_req = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_read", 32'(avm_read), 32'd0);
        check("midrst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        rsp_en = 1'b1;
        repeat (10) tick();
        c = cyc;
        i_addr = 25'h00078; i_req = 1'b1; rsp_data = 16'h4321;
        exp_cmd(1'b0, 32'h78, 32'h0);
        exp_rsp(1'b0, 32'h4321, 1'b0, 1'b1, c + 3);
        wait_ack(1'b0, 20);
        tick();
        i_req = 1'b0;

        // Back-to-back: request held through three transactions
        tick();
        c = cyc;
        i_addr = 25'h00090; i_req = 1'b1; rsp_data = 16'h9999;
        for (int t = 0; t < 3; t++) begin
            exp_cmd(1'b0, 32'h90, 32'h0);
            exp_rsp(1'b0, 32'h9999, 1'b0, 1'b1, c + 3 + 4 * t);
        end
        for (int t = 0; t < 3; t++) wait_ack(1'b0, 20);
        tick();
        i_req = 1'b0;

        repeat (5) tick();
        @(negedge clk);
        check("final_acks", 32'(acks_seen), 32'(acks_exp));
        check("final_rsp_q", 32'(rsp_q.size()), 32'd0);
        check("final_cmd_q", 32'(cmd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
